// File: rtl/mouse_tracker.sv
// PS/2 standard-mode packet decoder: 3-byte packets into a clamped absolute cursor
// position plus button levels and press pulses, all registered and updated once per packet.
module mouse_tracker #(
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240,
    parameter int INIT_X      = 160,
    parameter int INIT_Y      = 120,
    parameter int SHIFT       = 0,
    parameter int PKT_TIMEOUT = 250000
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic [7:0] iByte,
    input  logic       iByteValid,
    output logic [8:0] oMouseX,
    output logic [7:0] oMouseY,
    output logic       oLeftBtn,
    output logic       oRightBtn,
    output logic       oLeftClick,
    output logic       oRightClick,
    output logic       oPacketValid,
    output logic       oSyncError
);
    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

    localparam int TW = $clog2(PKT_TIMEOUT + 1);
    localparam logic signed [10:0] XMAX = 11'(SCREEN_W - 1);
    localparam logic signed [10:0] YMAX = 11'(SCREEN_H - 1);

    state_t state, state_nxt;
    logic [7:0]    dx_lo;
    logic [TW-1:0] tcnt;
    logic          apply, drop, timeout;

    // Flag bits kept from byte 0: {y_ovf, x_ovf, y_sign, x_sign, right, left}
    logic [5:0] flg;

    // Byte 0 bit 2 (middle button) is not reported by this block
    logic unused_middle;
    assign unused_middle = iByte[2];

    always_ff @(posedge clk) begin
        if (iReset) state <= WAIT_B0;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        drop      = 1'b0;
        // A strobe in the same cycle as the timeout wins
        timeout   = (state != WAIT_B0) && !iByteValid && (tcnt == TW'(PKT_TIMEOUT - 1));
        case (state)
            WAIT_B0: if (iByteValid) begin
                if (iByte[3]) state_nxt = WAIT_B1;
                else          drop = 1'b1;
            end
            WAIT_B1: begin
                if (iByteValid)   state_nxt = WAIT_B2;
                else if (timeout) state_nxt = WAIT_B0;
            end
            WAIT_B2: begin
                if (iByteValid) begin
                    state_nxt = WAIT_B0;
                    apply     = 1'b1;
                end else if (timeout) begin
                    state_nxt = WAIT_B0;
                end
            end
            default: state_nxt = WAIT_B0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            flg   <= '0;
            dx_lo <= '0;
            tcnt  <= '0;
        end else begin
            if (state == WAIT_B0 && iByteValid && iByte[3])
                flg <= {iByte[7:4], iByte[1:0]};
            if (state == WAIT_B1 && iByteValid)
                dx_lo <= iByte;
            if (iByteValid || state == WAIT_B0 || timeout) tcnt <= '0;
            else                                          tcnt <= tcnt + 1'b1;
        end
    end

    // Movement in 11-bit signed; PS/2 Y is up-positive so it is subtracted
    logic signed [8:0]  dx9, dy9;
    logic signed [10:0] dxs, dys, nx, ny;
    logic [8:0]         x_new;
    logic [7:0]         y_new;

    always_comb begin
        dx9   = {flg[2], dx_lo};
        dy9   = {flg[3], iByte};
        dxs   = flg[4] ? 11'sd0 : (11'(dx9) >>> SHIFT);
        dys   = flg[5] ? 11'sd0 : (11'(dy9) >>> SHIFT);
        nx    = $signed({2'b00, oMouseX}) + dxs;
        ny    = $signed({3'b000, oMouseY}) - dys;
        x_new = nx[10] ? 9'd0 : (nx > XMAX) ? XMAX[8:0] : nx[8:0];
        y_new = ny[10] ? 8'd0 : (ny > YMAX) ? YMAX[7:0] : ny[7:0];
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            oMouseX      <= 9'(INIT_X);
            oMouseY      <= 8'(INIT_Y);
            oLeftBtn     <= 1'b0;
            oRightBtn    <= 1'b0;
            oLeftClick   <= 1'b0;
            oRightClick  <= 1'b0;
            oPacketValid <= 1'b0;
            oSyncError   <= 1'b0;
        end else begin
            oPacketValid <= apply;
            oSyncError   <= drop | timeout;
            oLeftClick   <= apply & flg[0] & ~oLeftBtn;
            oRightClick  <= apply & flg[1] & ~oRightBtn;
            if (apply) begin
                oMouseX   <= x_new;
                oMouseY   <= y_new;
                oLeftBtn  <= flg[0];
                oRightBtn <= flg[1];
            end
        end
    end
endmodule

// File: tb/tb_mouse_tracker.sv
// Directed-vector bench for mouse_tracker: stimulus pushes expected events into a
// queue, a negedge monitor pops and compares on each packet/sync-error pulse.
module tb_mouse_tracker;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       iReset = 1'b1;
    logic [7:0] iByte = 8'h00;
    logic       iByteValid = 1'b0;
    logic [8:0] oMouseX;
    logic [7:0] oMouseY;
    logic       oLeftBtn, oRightBtn, oLeftClick, oRightClick, oPacketValid, oSyncError;

    always #5 clk = ~clk;

    mouse_tracker #(.PKT_TIMEOUT(TO)) dut (
        .clk(clk), .iReset(iReset), .iByte(iByte), .iByteValid(iByteValid),
        .oMouseX(oMouseX), .oMouseY(oMouseY), .oLeftBtn(oLeftBtn), .oRightBtn(oRightBtn),
        .oLeftClick(oLeftClick), .oRightClick(oRightClick),
        .oPacketValid(oPacketValid), .oSyncError(oSyncError)
    );

    typedef struct {
        bit is_err;
        int x, y;
        bit l, r, lc, rc;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        iByte      = b;
        iByteValid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            iByteValid = 1'b0;
        end
    endtask

    task automatic push_pkt(input int ex, input int ey, input bit l, input bit r, input bit lc, input bit rc);
        exp_t e;
        e = '{is_err: 1'b0, x: ex, y: ey, l: l, r: r, lc: lc, rc: rc};
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e = '{is_err: 1'b1, x: 0, y: 0, l: 1'b0, r: 1'b0, lc: 1'b0, rc: 1'b0};
        q.push_back(e);
    endtask

    task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input int ex, input int ey, input bit l, input bit r, input bit lc, input bit rc);
        send(b0);
        send(b1);
        push_pkt(ex, ey, l, r, lc, rc);
        send(b2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        iReset     = 1'b1;
        iByteValid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_x", 32'(oMouseX), 32'd160);
        chk("rst_y", 32'(oMouseY), 32'd120);
        chk("rst_flags", {26'd0, oLeftBtn, oRightBtn, oLeftClick, oRightClick, oPacketValid, oSyncError}, 32'd0);
        iReset = 1'b0;
    endtask

    // Monitor: outputs must hold between packets; every pulse must match the next expectation
    logic [20:0] last_out;
    logic [20:0] cur_out;
    exp_t        me;
    initial begin
        last_out = '0;
        forever begin
            @(negedge clk);
            cur_out = {oMouseX, oMouseY, oLeftBtn, oRightBtn, oLeftClick, oRightClick};
            if (!iReset) begin
                if (!oPacketValid)
                    chk("hold", 32'(cur_out), 32'({last_out[20:2], 2'b00}));
                if (oPacketValid || oSyncError) begin
                    if (q.size() == 0) begin
                        chk("unexpected_pulse", {30'd0, oSyncError, oPacketValid}, 32'd0);
                    end else begin
                        me = q.pop_front();
                        chk("pulse_kind", {30'd0, oSyncError, oPacketValid}, me.is_err ? 32'd2 : 32'd1);
                        if (!me.is_err) begin
                            chk("pkt_x", 32'(oMouseX), me.x);
                            chk("pkt_y", 32'(oMouseY), me.y);
                            chk("pkt_btn", {30'd0, oLeftBtn, oRightBtn}, {30'd0, me.l, me.r});
                            chk("pkt_click", {30'd0, oLeftClick, oRightClick}, {30'd0, me.lc, me.rc});
                        end
                    end
                end
            end
            last_out = cur_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        idle(3);

        // basic move, then back-to-back packets
        pkt(8'h08, 8'h05, 8'h03, 165, 117, 0, 0, 0, 0);
        idle(2);

        // negative X, saturating at 0
        do_reset();
        pkt(8'h18, 8'hF6, 8'h00, 150, 120, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++)
            pkt(8'h18, 8'hF6, 8'h00, (150 - 10 * k) < 0 ? 0 : 150 - 10 * k, 120, 0, 0, 0, 0);
        // dy = -200 pushes Y past the bottom edge
        pkt(8'h28, 8'h00, 8'h38, 0, 239, 0, 0, 0, 0);
        idle(1);
        pkt(8'h28, 8'h00, 8'h38, 0, 239, 0, 0, 0, 0);
        idle(2);

        // buttons
        pkt(8'h09, 8'h00, 8'h00, 0, 239, 1, 0, 1, 0);
        pkt(8'h09, 8'h00, 8'h00, 0, 239, 1, 0, 0, 0);
        pkt(8'h08, 8'h00, 8'h00, 0, 239, 0, 0, 0, 0);
        pkt(8'h0A, 8'h00, 8'h00, 0, 239, 0, 1, 0, 1);
        idle(2);

        // bad first byte is discarded
        push_err();
        send(8'h05);
        pkt(8'h08, 8'h01, 8'h01, 1, 238, 0, 0, 0, 0);
        idle(2);

        // partial packet times out
        push_err();
        send(8'h08);
        send(8'h05);
        idle(TO + 5);
        pkt(8'h08, 8'h02, 8'h00, 3, 238, 0, 0, 0, 0);
        idle(2);

        // third byte lands exactly on the timeout cycle: the byte wins
        send(8'h08);
        send(8'h05);
        idle(TO - 1);
        push_pkt(8, 235, 0, 0, 0, 0);
        send(8'h03);
        idle(2);

        // overflow bits suppress movement, buttons still update
        pkt(8'h49, 8'hFF, 8'h00, 8, 235, 1, 0, 1, 0);
        pkt(8'h88, 8'h00, 8'h10, 8, 235, 0, 0, 0, 0);
        idle(2);

        // reset in the middle of a packet
        send(8'h08);
        send(8'h05);
        do_reset();
        pkt(8'h08, 8'h01, 8'h02, 161, 118, 0, 0, 0, 0);
        // right edge clamp
        pkt(8'h08, 8'hFF, 8'h00, 319, 118, 0, 0, 0, 0);
        idle(5);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
